// File: rtl/btn_conditioner.sv
// btn_conditioner: conditions the four direction buttons for the block
// controller. Each lane synchronizes its raw button into the movement clock
// domain, debounces it, and emits a one-cycle pulse on every accepted press
// (plus optional auto-repeat pulses while the button stays held).
//
// Ports:
//   clk        movement clock; all state changes on its rising edge
//   rst        synchronous, active-high reset
//   btn_in     raw buttons {up, down, left, right} = [3:0], asynchronous
//   btn_level  debounced button level, registered
//   btn_pulse  one-cycle press/repeat pulse, registered

// One button lane: 2-flop synchronizer followed by the debounce/repeat FSM.
module btn_lane #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit REPEAT_EN       = 1'b0,
    parameter int REPEAT_DELAY    = 96,
    parameter int REPEAT_PERIOD   = 38
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic pulse
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] R_FIRST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] R_NEXT  = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        DOWN,
        WAIT_RELEASE
    } state_t;

    state_t        state, state_n;
    logic          s1, s2;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [RW-1:0] rcnt, rcnt_n;
    logic          first, first_n;
    logic          level_n, pulse_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= IDLE;
            dcnt  <= '0;
            rcnt  <= '0;
            first <= 1'b1;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            state <= state_n;
            dcnt  <= dcnt_n;
            rcnt  <= rcnt_n;
            first <= first_n;
            level <= level_n;
            pulse <= pulse_n;
        end
    end

    always_comb begin
        state_n = state;
        dcnt_n  = dcnt;
        rcnt_n  = rcnt;
        first_n = first;
        level_n = level;
        pulse_n = 1'b0;
        case (state)
            IDLE: begin
                if (s2) begin
                    state_n = WAIT_PRESS;
                    dcnt_n  = '0;
                end
            end
            WAIT_PRESS: begin
                if (!s2) begin
                    state_n = IDLE;
                    dcnt_n  = '0;
                end else if (dcnt == D_LAST) begin
                    state_n = DOWN;
                    level_n = 1'b1;
                    pulse_n = 1'b1;
                    rcnt_n  = '0;
                    first_n = 1'b1;
                end else begin
                    dcnt_n = dcnt + DW'(1);
                end
            end
            DOWN: begin
                if (!s2) begin
                    // rcnt is frozen so a bounce back to DOWN resumes the interval
                    state_n = WAIT_RELEASE;
                    dcnt_n  = '0;
                end else if (REPEAT_EN) begin
                    if (rcnt == (first ? R_FIRST : R_NEXT)) begin
                        pulse_n = 1'b1;
                        rcnt_n  = '0;
                        first_n = 1'b0;
                    end else begin
                        rcnt_n = rcnt + RW'(1);
                    end
                end
            end
            WAIT_RELEASE: begin
                if (s2) begin
                    // short dropout: resume the hold silently, level never fell
                    state_n = DOWN;
                    dcnt_n  = '0;
                end else if (dcnt == D_LAST) begin
                    state_n = IDLE;
                    level_n = 1'b0;
                end else begin
                    dcnt_n = dcnt + DW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit REPEAT_EN       = 1'b0,
    parameter int REPEAT_DELAY    = 96,
    parameter int REPEAT_PERIOD   = 38
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_in,
    output logic [3:0] btn_level,
    output logic [3:0] btn_pulse
);
    localparam int NUM_LANES = 4;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        btn_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_EN      (REPEAT_EN),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn_in[i]),
            .level(btn_level[i]),
            .pulse(btn_pulse[i])
        );
    end
endmodule
